// File: rtl/amstrad_vram_fetch.sv
// Video-RAM fetch sequencer: splits one BYTES-wide video word into per-CAS byte fetches,
// with an optional one-byte skew that carries the top lane into the next video phase.
module amstrad_vram_fetch #(
  parameter  int BYTES  = 2,
  parameter  int ADDR_W = 15,
  localparam int LANE_W = $clog2(BYTES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_n,
  input  logic                 ras_n,
  input  logic                 cas_n,
  input  logic                 de,
  input  logic                 shift_en,
  input  logic [ADDR_W-1:0]    crtc_addr,
  input  logic [8*BYTES-1:0]   vram_din,
  output logic [ADDR_W-1:0]    vram_addr,
  output logic [7:0]           vram_d,
  output logic [LANE_W-1:0]    lane,
  output logic                 byte_valid
);

  logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic [7:0]        vram_d_q, vram_d_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              byte_valid_q, byte_valid_d;
  logic [7:0]        carry_q, carry_d;
  logic              cas_n_dly_q, cas_n_dly_d;

  logic [7:0] cur_byte, prev_byte;
  logic       capture, cas_rise, lane_max;

  assign capture  = !ras_n && !cas_n;
  assign cas_rise = !ras_n && !cas_n_dly_q && cas_n;
  assign lane_max = (lane_q == LANE_W'(BYTES-1));

  // prev_byte is only consumed when lane_q > 0, so lane 0 leaves it at zero.
  always_comb begin
    cur_byte  = 8'h00;
    prev_byte = 8'h00;
    for (int k = 0; k < BYTES; k++) begin
      if (lane_q == LANE_W'(k)) begin
        cur_byte = vram_din[8*k +: 8];
        if (k > 0) prev_byte = vram_din[8*(k-1) +: 8];
      end
    end
  end

  always_comb begin
    vram_addr_d  = vram_addr_q;
    vram_d_d     = vram_d_q;
    lane_d       = lane_q;
    byte_valid_d = 1'b0;
    carry_d      = carry_q;
    cas_n_dly_d  = cas_n;

    if (!cpu_n) begin
      lane_d = '0;
    end else begin
      vram_addr_d = crtc_addr;
      if (capture) begin
        if (!shift_en) begin
          vram_d_d = cur_byte;
        end else begin
          vram_d_d = (lane_q == '0) ? carry_q : prev_byte;
          if (lane_max) carry_d = de ? vram_din[8*(BYTES-1) +: 8] : 8'h00;
        end
      end
      if (cas_rise) begin
        byte_valid_d = 1'b1;
        lane_d       = lane_max ? lane_q : lane_q + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vram_addr_q  <= '0;
      vram_d_q     <= 8'h00;
      lane_q       <= '0;
      byte_valid_q <= 1'b0;
      carry_q      <= 8'h00;
      cas_n_dly_q  <= 1'b1;
    end else begin
      vram_addr_q  <= vram_addr_d;
      vram_d_q     <= vram_d_d;
      lane_q       <= lane_d;
      byte_valid_q <= byte_valid_d;
      carry_q      <= carry_d;
      cas_n_dly_q  <= cas_n_dly_d;
    end
  end

  assign vram_addr  = vram_addr_q;
  assign vram_d     = vram_d_q;
  assign lane       = lane_q;
  assign byte_valid = byte_valid_q;

endmodule

// File: tb/tb_amstrad_vram_fetch.sv
// Scoreboard bench: stimulus pushes expected (byte, lane) per fetch; a monitor pops on byte_valid.
module tb_amstrad_vram_fetch;

  logic        clk = 1'b0;
  logic        reset, cpu_n2, cpu_n4, ras_n, cas_n, de, shift_en;
  logic [14:0] crtc_addr;
  logic [15:0] din2;
  logic [31:0] din4;
  logic [14:0] addr2, addr4;
  logic [7:0]  vd2, vd4;
  logic [0:0]  lane2;
  logic [1:0]  lane4;
  logic        bv2, bv4;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [7:0] d; int lane; } exp_t;
  exp_t q2[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  amstrad_vram_fetch #(.BYTES(2), .ADDR_W(15)) dut2 (
    .clk(clk), .reset(reset), .cpu_n(cpu_n2), .ras_n(ras_n), .cas_n(cas_n),
    .de(de), .shift_en(shift_en), .crtc_addr(crtc_addr), .vram_din(din2),
    .vram_addr(addr2), .vram_d(vd2), .lane(lane2), .byte_valid(bv2));

  amstrad_vram_fetch #(.BYTES(4), .ADDR_W(15)) dut4 (
    .clk(clk), .reset(reset), .cpu_n(cpu_n4), .ras_n(ras_n), .cas_n(cas_n),
    .de(de), .shift_en(shift_en), .crtc_addr(crtc_addr), .vram_din(din4),
    .vram_addr(addr4), .vram_d(vd4), .lane(lane4), .byte_valid(bv4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push2(input logic [7:0] d, input int l);
    exp_t e;
    e.d = d; e.lane = l;
    q2.push_back(e);
  endtask

  task automatic push4(input logic [7:0] d, input int l);
    exp_t e;
    e.d = d; e.lane = l;
    q4.push_back(e);
  endtask

  task automatic pulse();
    cas_n = 1'b0; step(); step();
    cas_n = 1'b1; step(); step();
  endtask

  task automatic phase_start2(input logic [15:0] d);
    din2 = d; cpu_n2 = 1'b1; ras_n = 1'b0; cas_n = 1'b1; step();
  endtask

  task automatic phase_end();
    cpu_n2 = 1'b0; cpu_n4 = 1'b0; ras_n = 1'b1; cas_n = 1'b1; step();
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bv2) begin
        if (q2.size() == 0) chk("b2_unexpected_valid", 32'(vd2), 32'hFFFF_FFFF);
        else begin
          e = q2.pop_front();
          chk("b2_byte", 32'(vd2), 32'(e.d));
          chk("b2_lane", 32'(lane2), 32'(e.lane));
        end
      end
      if (bv4) begin
        if (q4.size() == 0) chk("b4_unexpected_valid", 32'(vd4), 32'hFFFF_FFFF);
        else begin
          e = q4.pop_front();
          chk("b4_byte", 32'(vd4), 32'(e.d));
          chk("b4_lane", 32'(lane4), 32'(e.lane));
        end
      end
    end
  endtask

  task automatic stimulus();
    reset = 1'b1; cpu_n2 = 1'b1; cpu_n4 = 1'b1; ras_n = 1'b0; cas_n = 1'b0;
    de = 1'b1; shift_en = 1'b0; crtc_addr = 15'h7FFF; din2 = 16'hFFFF; din4 = 32'hFFFF_FFFF;
    step(); step();
    chk("rst_addr2", 32'(addr2), 0);
    chk("rst_d2", 32'(vd2), 0);
    chk("rst_lane2", 32'(lane2), 0);
    chk("rst_bv2", 32'(bv2), 0);
    chk("rst_lane4", 32'(lane4), 0);
    reset = 1'b0;
    phase_end();

    // Normal mode, 2 lanes, plus address latency and CPU-phase hold
    crtc_addr = 15'h1234;
    phase_start2(16'hA55A);
    chk("addr_latency", 32'(addr2), 32'h1234);
    push2(8'h5A, 1); pulse();
    push2(8'hA5, 1); pulse();
    phase_end();
    crtc_addr = 15'h0F0F; step();
    chk("cpu_hold_addr", 32'(addr2), 32'h1234);
    chk("cpu_hold_d", 32'(vd2), 32'hA5);
    chk("cpu_lane_zero", 32'(lane2), 0);

    // Skew mode with de=1 across three phases
    shift_en = 1'b1; de = 1'b1;
    phase_start2(16'h1122);
    push2(8'h00, 1); pulse(); push2(8'h22, 1); pulse(); phase_end();
    phase_start2(16'h3344);
    push2(8'h11, 1); pulse(); push2(8'h44, 1); pulse(); phase_end();
    phase_start2(16'h5566);
    push2(8'h33, 1); pulse(); push2(8'h66, 1); pulse(); phase_end();

    // de=0 clears the carried byte
    de = 1'b0;
    phase_start2(16'h9988);
    push2(8'h55, 1); pulse(); push2(8'h88, 1); pulse(); phase_end();
    de = 1'b1;
    phase_start2(16'hAABB);
    push2(8'h00, 1); pulse(); push2(8'hBB, 1); pulse(); phase_end();

    // Four lanes, fifth pulse re-fetches the saturated lane
    shift_en = 1'b0;
    din4 = 32'h4433_2211; cpu_n4 = 1'b1; ras_n = 1'b0; cas_n = 1'b1; step();
    push4(8'h11, 1); pulse();
    push4(8'h22, 2); pulse();
    push4(8'h33, 3); pulse();
    push4(8'h44, 3); pulse();
    push4(8'h44, 3); pulse();
    chk("b4_lane_saturated", 32'(lane4), 3);
    phase_end();

    // cpu_n falls on the CAS rising edge
    phase_start2(16'hA55A);
    cas_n = 1'b0; step(); step();
    cas_n = 1'b1; cpu_n2 = 1'b0; ras_n = 1'b1; step();
    chk("simul_lane", 32'(lane2), 0);
    chk("simul_bv", 32'(bv2), 0);
    step();
    chk("simul_bv_later", 32'(bv2), 0);
    phase_start2(16'h0F0E);
    push2(8'h0E, 1); pulse(); phase_end();

    // Reset mid-phase with lane=1 and carry=77
    shift_en = 1'b1; de = 1'b1;
    phase_start2(16'h77AA);
    push2(8'hAA, 1); pulse(); push2(8'hAA, 1); pulse();
    cas_n = 1'b0; step();
    reset = 1'b1; step();
    chk("midrst_addr", 32'(addr2), 0);
    chk("midrst_d", 32'(vd2), 0);
    chk("midrst_lane", 32'(lane2), 0);
    chk("midrst_bv", 32'(bv2), 0);
    reset = 1'b0; cas_n = 1'b1; step();
    din2 = 16'h1357;
    push2(8'h00, 1); pulse(); push2(8'h57, 1); pulse();
    phase_end();
    step(); step();
    chk("q2_drained", 32'(q2.size()), 0);
    chk("q4_drained", 32'(q4.size()), 0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #200000;
        chk("watchdog_timeout", 1, 0);
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
